// File: rtl/embedded_lab_top_if.sv
// LCD write port: host-side request (data, register select, start) and the
// controller's completion flag plus the HD44780 pin bundle.
interface embedded_lab_top_if;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (
    output iDATA, iRS, iStart,
    input  oDone, LCD_DATA, LCD_RW, LCD_EN, LCD_RS
  );

  modport slave (
    input  iDATA, iRS, iStart,
    output oDone, LCD_DATA, LCD_RW, LCD_EN, LCD_RS
  );
endinterface

// File: rtl/embedded_lab_top.sv
// Lab top: combinational 8-bit ALU, 18-LED dance sequencer and a one-byte
// HD44780 write controller. The three share only clock and reset.
module embedded_lab_top #(
  parameter int unsigned DANCE_DIV  = 1,
  parameter int unsigned CLK_DIVIDE = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic [7:0]               a,
  input  logic [7:0]               b,
  input  logic [1:0]               op,
  output logic [7:0]               result1,
  output logic [7:0]               result2,
  input  logic [3:0]               SW,
  output logic [4:0]               position,
  output logic [17:0]              led,
  embedded_lab_top_if.slave        lcd
);

  // ---------------- ALU ----------------
  logic [15:0] wide;

  always_comb begin
    wide    = 16'h0000;
    result1 = 8'h00;
    result2 = 8'h00;
    unique case (op)
      2'd0: begin
        wide    = {8'h00, a} + {8'h00, b};
        result1 = wide[7:0];
        result2 = wide[15:8];
      end
      2'd1: begin
        result1 = a - b;
        result2 = {7'b0, (a < b)};
      end
      2'd2: begin
        wide    = {8'h00, a} * {8'h00, b};
        result1 = wide[7:0];
        result2 = wide[15:8];
      end
      default: begin
        // Divide-by-zero returns all-ones quotient and passes a through as remainder.
        if (b == 8'h00) begin
          result1 = 8'hFF;
          result2 = a;
        end else begin
          result1 = a / b;
          result2 = a % b;
        end
      end
    endcase
  end

  // ---------------- Dance sequencer ----------------
  localparam int unsigned PW = (DANCE_DIV > 1) ? $clog2(DANCE_DIV) : 1;
  localparam logic [4:0]  PosMax = 5'd17;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    pos_q, pos_d;
  logic          dir_up_q, dir_up_d;
  logic          step;

  assign step = (presc_q == PW'(DANCE_DIV - 1));

  always_comb begin
    presc_d  = step ? '0 : presc_q + PW'(1);
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    if (step) begin
      unique case (SW[1:0])
        2'd0: pos_d = (pos_q == PosMax) ? 5'd0 : pos_q + 5'd1;
        2'd1: pos_d = (pos_q == 5'd0) ? PosMax : pos_q - 5'd1;
        2'd2: begin
          // Reverse on the endpoint itself so neither end is shown twice.
          if (dir_up_q) begin
            if (pos_q >= PosMax) begin
              pos_d    = PosMax - 5'd1;
              dir_up_d = 1'b0;
            end else begin
              pos_d = pos_q + 5'd1;
            end
          end else begin
            if (pos_q == 5'd0) begin
              pos_d    = 5'd1;
              dir_up_d = 1'b1;
            end else begin
              pos_d = pos_q - 5'd1;
            end
          end
        end
        default: pos_d = pos_q;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      presc_q  <= '0;
      pos_q    <= 5'd0;
      dir_up_q <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign position = pos_q;
  assign led      = 18'd1 << pos_q;

  // ---------------- LCD write controller ----------------
  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StDone} lcd_state_e;

  localparam int unsigned CW = $clog2(CLK_DIVIDE + 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          start_edge;

  assign start_edge = lcd.iStart & ~start_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          data_d  = lcd.iDATA;
          rs_d    = lcd.iRS;
          done_d  = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = StPulse;
      end
      StPulse: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CLK_DIVIDE - 1)) begin
          en_d    = 1'b0;
          state_d = StDone;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= lcd.iStart;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign lcd.LCD_DATA = data_q;
  assign lcd.LCD_RS   = rs_q;
  assign lcd.LCD_EN   = en_q;
  assign lcd.LCD_RW   = 1'b0;
  assign lcd.oDone    = done_q;

endmodule

// File: tb/tb_embedded_lab_top.sv
// Self-checking bench for embedded_lab_top: ALU vector table, dance
// sequences and LCD write handshakes, checked through an expected-value queue.
module tb_embedded_lab_top;
  logic        iCLK;
  logic        iRST_N;
  logic [7:0]  a, b;
  logic [1:0]  op;
  logic [7:0]  result1, result2;
  logic [3:0]  SW;
  logic [4:0]  position;
  logic [17:0] led;

  embedded_lab_top_if lcd ();

  embedded_lab_top #(
    .DANCE_DIV  (1),
    .CLK_DIVIDE (16)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .a        (a),
    .b        (b),
    .op       (op),
    .result1  (result1),
    .result2  (result2),
    .SW       (SW),
    .position (position),
    .led      (led),
    .lcd      (lcd.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] r1;
    logic [7:0] r2;
  } alu_vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_pop(input string name, input int actual);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d expected <empty scoreboard>", name, actual);
    end else begin
      e = exp_q.pop_front();
      check(name, actual, e);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Steps the dance once per queued expectation, also checking led one-hot.
  task automatic run_dance(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_pop(name, int'(position));
      check({name, "_led"}, int'(led), int'(18'd1 << position));
    end
  endtask

  // Waits up to 40 clocks after an accept edge; returns when oDone was first
  // seen and how many sampled cycles had LCD_EN high.
  task automatic wait_write(input int change_at, input logic [7:0] new_data,
                            output int done_at, output int en_cnt);
    done_at = 0;
    en_cnt  = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      if (n == change_at) lcd.iDATA = new_data;
      tick();
      if (lcd.LCD_EN === 1'b1) en_cnt++;
      if (lcd.LCD_RW !== 1'b0) check("lcd_rw", int'(lcd.LCD_RW), 0);
      if (lcd.oDone === 1'b1) done_at = n;
    end
  endtask

  alu_vec_t vecs[9];
  int done_at, en_cnt, en_seen;

  initial begin
    iRST_N     = 1'b0;
    a          = 8'd0;
    b          = 8'd0;
    op         = 2'd0;
    SW         = 4'd0;
    lcd.iDATA  = 8'h00;
    lcd.iRS    = 1'b0;
    lcd.iStart = 1'b0;

    vecs[0] = '{8'd5,   8'd2,   2'd0, 8'd7,   8'd0};
    vecs[1] = '{8'd5,   8'd2,   2'd1, 8'd3,   8'd0};
    vecs[2] = '{8'd5,   8'd2,   2'd2, 8'd10,  8'd0};
    vecs[3] = '{8'd5,   8'd2,   2'd3, 8'd2,   8'd1};
    vecs[4] = '{8'd250, 8'd10,  2'd0, 8'd4,   8'd1};
    vecs[5] = '{8'd1,   8'd2,   2'd1, 8'd255, 8'd1};
    vecs[6] = '{8'd7,   8'd0,   2'd3, 8'd255, 8'd7};
    vecs[7] = '{8'd200, 8'd200, 2'd2, 8'h40,  8'h9C};
    vecs[8] = '{8'd255, 8'd255, 2'd2, 8'h01,  8'hFE};

    // ALU is combinational and works during reset.
    for (int i = 0; i < 9; i++) begin
      a  = vecs[i].a;
      b  = vecs[i].b;
      op = vecs[i].op;
      exp_q.push_back(int'(vecs[i].r1));
      exp_q.push_back(int'(vecs[i].r2));
      #1;
      check_pop($sformatf("alu%0d_r1", i), int'(result1));
      check_pop($sformatf("alu%0d_r2", i), int'(result2));
    end

    tick();
    check("rst_position", int'(position), 0);
    check("rst_led", int'(led), 1);
    check("rst_en", int'(lcd.LCD_EN), 0);
    check("rst_done", int'(lcd.oDone), 0);
    check("rst_data", int'(lcd.LCD_DATA), 0);
    check("rst_rw", int'(lcd.LCD_RW), 0);

    // Release between edges; ascending from 0.
    #2 iRST_N = 1'b1;
    SW = 4'd0;
    for (int v = 1; v <= 17; v++) exp_q.push_back(v);
    exp_q.push_back(0);
    run_dance("asc", 18);

    SW = 4'd1;
    for (int v = 17; v >= 0; v--) exp_q.push_back(v);
    exp_q.push_back(17);
    run_dance("desc", 19);

    // Ping-pong from 17: 16..0, 1..17, 16.
    SW = 4'd2;
    for (int v = 16; v >= 0; v--) exp_q.push_back(v);
    for (int v = 1; v <= 17; v++) exp_q.push_back(v);
    exp_q.push_back(16);
    run_dance("ping", 35);

    SW = 4'd3;
    for (int i = 0; i < 5; i++) exp_q.push_back(16);
    run_dance("hold", 5);

    // LCD command write.
    lcd.iDATA  = 8'h0E;
    lcd.iRS    = 1'b0;
    lcd.iStart = 1'b1;
    tick();
    lcd.iStart = 1'b0;
    wait_write(0, 8'h00, done_at, en_cnt);
    exp_q.push_back(18);
    exp_q.push_back(16);
    check_pop("cmd_done_at", done_at);
    check_pop("cmd_en_cycles", en_cnt);
    check("cmd_data", int'(lcd.LCD_DATA), 8'h0E);
    check("cmd_rs", int'(lcd.LCD_RS), 0);
    for (int i = 0; i < 5; i++) tick();
    check("cmd_done_stays", int'(lcd.oDone), 1);
    check("cmd_data_holds", int'(lcd.LCD_DATA), 8'h0E);

    // Data write with iStart held high and iDATA changed mid-pulse.
    lcd.iDATA  = 8'h41;
    lcd.iRS    = 1'b1;
    lcd.iStart = 1'b1;
    tick();
    check("dat_done_clr", int'(lcd.oDone), 0);
    wait_write(5, 8'h55, done_at, en_cnt);
    exp_q.push_back(18);
    check_pop("dat_done_at", done_at);
    check("dat_data", int'(lcd.LCD_DATA), 8'h41);
    check("dat_rs", int'(lcd.LCD_RS), 1);
    en_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (lcd.LCD_EN === 1'b1) en_seen++;
    end
    check("held_no_retrigger", en_seen, 0);
    check("held_done", int'(lcd.oDone), 1);
    check("held_data", int'(lcd.LCD_DATA), 8'h41);

    // Fresh edge after completion starts a second write.
    lcd.iStart = 1'b0;
    tick();
    lcd.iStart = 1'b1;
    tick();
    lcd.iStart = 1'b0;
    check("dat2_done_clr", int'(lcd.oDone), 0);
    check("dat2_data", int'(lcd.LCD_DATA), 8'h55);
    wait_write(0, 8'h00, done_at, en_cnt);
    exp_q.push_back(18);
    check_pop("dat2_done_at", done_at);

    // Asynchronous reset during the enable pulse.
    lcd.iDATA  = 8'hA5;
    lcd.iRS    = 1'b1;
    lcd.iStart = 1'b1;
    tick();
    lcd.iStart = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_en_high", int'(lcd.LCD_EN), 1);
    #2 iRST_N = 1'b0;
    #1;
    check("arst_en", int'(lcd.LCD_EN), 0);
    check("arst_done", int'(lcd.oDone), 0);
    check("arst_data", int'(lcd.LCD_DATA), 0);
    check("arst_rs", int'(lcd.LCD_RS), 0);
    check("arst_position", int'(position), 0);
    check("arst_led", int'(led), 1);
    tick();
    #2 iRST_N = 1'b1;

    lcd.iDATA  = 8'h3C;
    lcd.iRS    = 1'b0;
    lcd.iStart = 1'b1;
    tick();
    lcd.iStart = 1'b0;
    wait_write(0, 8'h00, done_at, en_cnt);
    exp_q.push_back(18);
    exp_q.push_back(16);
    check_pop("post_rst_done_at", done_at);
    check_pop("post_rst_en_cycles", en_cnt);
    check("post_rst_data", int'(lcd.LCD_DATA), 8'h3C);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
